uart_rx: RTL and testbench
==========================

# uart_rx

Parametrised asynchronous serial receiver, next generation of the single-byte receive path feeding the controller's command decoder. Oversamples the line with a programmable clock divider, validates the start bit, samples each bit at mid-period, and checks stop and optional parity bits. Received words are held in a valid/ack handshake with overrun detection. It sits between the board RX pin and the command parser.

## Interface
- `CLKS_PER_BIT`, 52: clock cycles per bit period; legal range ≥ 4.
- `DATA_BITS`, 8: data bits per frame, LSB first; legal 5..9.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Only used with parity compiled in.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `uart_data`  in  1: raw serial line, idle high, asynchronous to `clk`.
- `rx_ack`  in  1: one-cycle pulse; consumes the held word.
- `rx_data`  out  DATA_BITS: last received word. Reset value 0.
- `rx_valid`  out  1: level; word pending. Reset value 0.
- `frame_err`  out  1: stop bit of the held word sampled low. Reset value 0.
- `parity_err`  out  1: parity mismatch on the held word. Reset value 0.
- `overrun`  out  1: sticky; a word was overwritten before ack. Reset value 0.
- `busy`  out  1: high in every state except IDLE. Reset value 0.

## Operation
- Line passes through a 2-FF synchroniser that resets to 1. All logic uses the synchronised line `rx_s`.
- `HALF = CLKS_PER_BIT/2`, rounded down. The bit counter `cnt` is `$clog2(CLKS_PER_BIT)` wide and counts down. Sampling happens on the edge where `cnt == 0` in a sampling state.
- States and transitions:
  - IDLE: `rx_s == 0` → START, load `cnt = HALF-1`.
  - START: at sample, `rx_s == 1` → IDLE (false start, no flags). Otherwise → DATA, load `cnt = CLKS_PER_BIT-1` and clear the bit index.
  - DATA: at each sample, shift `rx_s` into the MSB of the shift register. After the `DATA_BITS`-th sample → PARITY (if compiled) else STOP, reloading `cnt`.
  - PARITY: at sample, record mismatch → STOP, reload `cnt`.
  - STOP: at sample, update outputs (below). `rx_s == 1` → IDLE. `rx_s == 0` → BREAK.
  - BREAK: wait for `rx_s == 1` → IDLE. Prevents a held-low line from retriggering.
- Word completion (the STOP sample edge):
  - `rx_data` ← shift register.
  - `frame_err` ← `!rx_s`.
  - `parity_err` ← mismatch.
  - `rx_valid` ← 1.
  - `overrun` ← 1 if `rx_valid` was already 1 and `rx_ack` is not asserted that cycle.
- `rx_ack` with `rx_valid == 1` and no completion: clears `rx_valid`, `overrun`, `frame_err` and `parity_err` next edge. `rx_ack` while `rx_valid == 0` is ignored.
- Simultaneous `rx_ack` and completion: the new word is loaded, `rx_valid` stays 1, `overrun` is cleared (not set).
- `rst_n` low at any time: the FSM returns to IDLE immediately, and all outputs and counters go to reset values. The frame in flight is discarded.

## Timing
- Pin falling edge → IDLE→START transition on the 3rd rising edge afterwards (edge E0; two synchroniser edges plus the FSM edge).
- Bit k (start bit = 0) is sampled at E0 + HALF + k·CLKS_PER_BIT.
- Completion edge E0 + HALF + (DATA_BITS+P+1)·CLKS_PER_BIT, where P = 1 with parity compiled in, else 0. `rx_valid` is high from the cycle after that edge.
- `rx_ack` → `rx_valid` low one cycle later.
- Back-to-back frames: the next start bit is detected without gap cycles, as IDLE is re-entered at mid-stop-bit.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists and one parity bit is expected after the data bits.
  - Expected parity = XOR of the data bits, inverted when `PARITY_ODD` = 1.
  - `parity_err` reflects a mismatch.
- `UART_RX_PARITY_EN` undefined: there is no PARITY state, P = 0, `parity_err` is tied to 0, and `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg`: the state enum `uart_rx_state_e` (IDLE, START, DATA, PARITY, STOP, BREAK) and a `UART_CLKS_PER_BIT_DEFAULT` = 52 constant. The package is reused by a future transmitter.
- One sub-module, `bit_sync`: a 2-FF synchroniser with a parametrised reset value (1 here), async active-low reset.
- Elaboration-time checks reject `CLKS_PER_BIT` < 4 and `DATA_BITS` outside 5..9.

## Test plan
- CLKS_PER_BIT=16, 8N1, send 0xA5 → `rx_data`=0xA5, `rx_valid` rises at E0+152, no error flags; `rx_ack` clears `rx_valid` one cycle later.
- 4-cycle low glitch on idle line → START then back to IDLE, `busy` pulses, `rx_valid` stays 0.
- Frame 0x3C with stop bit forced low for 2 bit periods → `rx_valid`=1 and `frame_err`=1. FSM sits in BREAK until the line is high, and the next frame 0x11 is received correctly.
- Two frames 0x01, 0x02 without ack → `rx_data`=0x02, `overrun`=1. Repeat with `rx_ack` pulsed on the second completion edge → `overrun`=0, `rx_valid`=1.
- `UART_RX_PARITY_EN`, `PARITY_ODD`=0, send 0x07 with parity bit 0 → `parity_err`=1. Send it with parity bit 1 → `parity_err`=0, completion at E0+168.
- `rst_n` pulsed low mid-DATA → all outputs 0 and `busy`=0 immediately. The following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and defaults for the receive and future transmit paths
package uart_pkg;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 52;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_e;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - two-flop synchroniser for a single asynchronous bit, reset value parametrised
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with valid/ack hold and overrun detect
// Optional parity bit compiled in with UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_data,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_chk_cpb
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
    $error("uart_rx: DATA_BITS must be within 5..9");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_odd
    $error("uart_rx: PARITY_ODD must be 0 or 1");
  end

  uart_rx_state_e       state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
  logic                 tick;
  logic                 done;

  bit_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_data),
    .q     (rx_s)
  );

  assign tick = (cnt == '0);
  assign done = (state == STOP) && tick;
  assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic mism;
  logic parity_err_q;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      mism         <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (!tick) cnt <= cnt - 1'b1;

      // Ack only clears when no new word lands on the same edge.
      if (rx_ack && rx_valid && !done) begin
        rx_valid  <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_q <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= CNT_HALF;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              cnt   <= CNT_FULL;
              idx   <= '0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            cnt   <= CNT_FULL;
            idx   <= idx + 1'b1;
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            mism  <= rx_s != ((^shreg) ^ (PARITY_ODD != 0));
            state <= STOP;
            cnt   <= CNT_FULL;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            rx_data   <= shreg;
            frame_err <= !rx_s;
            rx_valid  <= 1'b1;
            overrun   <= rx_valid && !rx_ack;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= mism;
`endif
            state <= rx_s ? IDLE : BREAK;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx, table vectors plus randomized frames
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int PODD = 0;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_data = 1'b1;
  logic          rx_ack = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int busy_cnt = 0;
  logic prev_v = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(PODD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_data  (uart_data),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_v) rise_cyc = cyc;
    prev_v = rx_valid;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       par_ok;
    logic       stop_lvl;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Completion edge = pin fall + 2 sync edges + FSM edge + HALF + (DB+P+1) bit periods.
  task automatic send(input logic [7:0] d, input logic par_ok, input logic stop_lvl,
                      input int stop_bits, input bit ack_on_done, input int rst_at,
                      output int comp);
    logic bits[$];
    int c0;
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (P == 1) bits.push_back(((^d) ^ (PODD != 0)) ^ !par_ok);
    for (int i = 0; i < stop_bits; i++) bits.push_back(stop_lvl);
    @(negedge clk);
    c0 = cyc;
    comp = c0 + 3 + HALF + (DB + P + 1) * CPB;
    for (int k = 0; k < bits.size() * CPB; k++) begin
      if (k > 0) @(negedge clk);
      uart_data = bits[k / CPB];
      rx_ack = ack_on_done && (cyc + 1 == comp);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        uart_data = 1'b1;
        rx_ack = 1'b0;
        return;
      end
    end
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic check_word(input string name, input logic [7:0] d, input logic fe,
                            input logic pe, input logic ovr, input int comp, input bit timing);
    chk({name, "_valid"}, rx_valid, 1);
    chk({name, "_data"}, rx_data, d);
    chk({name, "_frame_err"}, frame_err, fe);
    chk({name, "_parity_err"}, parity_err, pe);
    chk({name, "_overrun"}, overrun, ovr);
    if (timing) chk({name, "_valid_cycle"}, rise_cyc, comp);
  endtask

  task automatic do_ack(input string name);
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    chk({name, "_ack_valid"}, rx_valid, 0);
    chk({name, "_ack_flags"}, {frame_err, parity_err, overrun}, 0);
  endtask

  initial begin
    vec_t tbl[6];
    int comp;
    int b0;
    logic [7:0] d;
    logic pok, slv;

    tbl[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
    tbl[3] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};
    tbl[4] = '{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, (P == 1)};
    tbl[5] = '{8'h6E, 1'b0, 1'b0, 8'h6E, 1'b1, (P == 1)};

    repeat (3) @(negedge clk);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_flags", {frame_err, parity_err, overrun}, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send(8'hA5, 1'b1, 1'b1, 1, 1'b0, -1, comp);
    check_word("a5", 8'hA5, 1'b0, 1'b0, 1'b0, comp, 1'b1);
    do_ack("a5");

    b0 = busy_cnt;
    uart_data = 1'b0;
    repeat (4) @(negedge clk);
    uart_data = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_busy_cycles", busy_cnt - b0, HALF);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_valid", rx_valid, 0);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].data, tbl[i].par_ok, tbl[i].stop_lvl, 1, 1'b0, -1, comp);
      uart_data = 1'b1;
      repeat (CPB) @(negedge clk);
      check_word($sformatf("tbl%0d", i), tbl[i].exp_data, tbl[i].exp_fe, tbl[i].exp_pe,
                 1'b0, comp, 1'b1);
      do_ack($sformatf("tbl%0d", i));
    end

    send(8'h3C, 1'b1, 1'b0, 2, 1'b0, -1, comp);
    chk("break_busy_held", busy, 1);
    check_word("break", 8'h3C, 1'b1, 1'b0, 1'b0, comp, 1'b1);
    uart_data = 1'b1;
    repeat (4) @(negedge clk);
    chk("break_exit_busy", busy, 0);
    do_ack("break");
    send(8'h11, 1'b1, 1'b1, 1, 1'b0, -1, comp);
    check_word("after_break", 8'h11, 1'b0, 1'b0, 1'b0, comp, 1'b1);
    do_ack("after_break");

    send(8'h01, 1'b1, 1'b1, 1, 1'b0, -1, comp);
    send(8'h02, 1'b1, 1'b1, 1, 1'b0, -1, comp);
    check_word("overrun", 8'h02, 1'b0, 1'b0, 1'b1, comp, 1'b0);
    do_ack("overrun");
    send(8'h01, 1'b1, 1'b1, 1, 1'b0, -1, comp);
    send(8'h02, 1'b1, 1'b1, 1, 1'b1, -1, comp);
    check_word("ack_on_done", 8'h02, 1'b0, 1'b0, 1'b0, comp, 1'b0);
    do_ack("ack_on_done");

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b0, 1'b1, 1, 1'b0, -1, comp);
    check_word("par_bad", 8'h07, 1'b0, 1'b1, 1'b0, comp, 1'b1);
    do_ack("par_bad");
    send(8'h07, 1'b1, 1'b1, 1, 1'b0, -1, comp);
    check_word("par_good", 8'h07, 1'b0, 1'b0, 1'b0, comp, 1'b1);
    do_ack("par_good");
`endif

    send(8'h33, 1'b1, 1'b1, 1, 1'b0, -1, comp);
    send(8'h99, 1'b1, 1'b1, 1, 1'b0, 4 * CPB, comp);
    repeat (2 * CPB) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", rx_valid, 0);
    send(8'h5A, 1'b1, 1'b1, 1, 1'b0, -1, comp);
    check_word("post_rst", 8'h5A, 1'b0, 1'b0, 1'b0, comp, 1'b1);
    do_ack("post_rst");

    // Reference: word equals sent byte, frame error iff stop low, parity error iff bad parity bit sent.
    for (int i = 0; i < 20; i++) begin
      d   = 8'($urandom_range(0, 255));
      pok = ($urandom_range(0, 3) != 0);
      slv = ($urandom_range(0, 4) != 0);
      send(d, pok, slv, 1, 1'b0, -1, comp);
      uart_data = 1'b1;
      repeat (CPB) @(negedge clk);
      check_word($sformatf("rnd%0d", i), d, !slv, (P == 1) && !pok, 1'b0, comp, 1'b1);
      do_ack($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
